// File: rtl/wbu.sv
// Writeback stage: 32 x XLEN register file with two decode read ports, retire counter,
// commit trace and ebreak halt with a0 exit-code capture. Define WBU_BYPASS_EN for write-through reads.
module wbu #(
    parameter int XLEN  = 64,
    parameter int NREG  = 32,
    parameter int CNT_W = 64
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             instr_valid,
    input  logic             mmu_valid,
    input  logic             mmu_wb_en,
    input  logic [4:0]       mmu_index_rd,
    input  logic [XLEN-1:0]  mmu_wb_data,
    input  logic             mmu_ebreak_en,
    input  logic [XLEN-1:0]  mmu_pc,
    input  logic [31:0]      mmu_instr,
    input  logic [4:0]       rs1_index,
    input  logic [4:0]       rs2_index,
    output logic [XLEN-1:0]  rs1_data,
    output logic [XLEN-1:0]  rs2_data,
    output logic             commit_valid,
    output logic [XLEN-1:0]  commit_pc,
    output logic [31:0]      commit_instr,
    output logic [CNT_W-1:0] retire_cnt,
    output logic             halt,
    output logic [XLEN-1:0]  exit_code
);

    localparam logic [4:0] A0_IDX = 5'd10;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_t;

    state_t          state;
    logic [XLEN-1:0] regs [NREG];

    logic            vld_p0;
    logic            wr_en_p0;
    logic [XLEN-1:0] a0_p0;

    // Stage p0: retire qualification and the a0 value as seen after this retire
    assign vld_p0   = instr_valid & mmu_valid & (state == RUN);
    assign wr_en_p0 = vld_p0 & mmu_wb_en & (mmu_index_rd != 5'd0);
    assign a0_p0    = (wr_en_p0 && (mmu_index_rd == A0_IDX)) ? mmu_wb_data : regs[A0_IDX];

    always_comb begin
        rs1_data = regs[rs1_index];
        rs2_data = regs[rs2_index];
`ifdef WBU_BYPASS_EN
        if (wr_en_p0 && (rs1_index == mmu_index_rd)) rs1_data = mmu_wb_data;
        if (wr_en_p0 && (rs2_index == mmu_index_rd)) rs2_data = mmu_wb_data;
`endif
        if (rs1_index == 5'd0) rs1_data = '0;
        if (rs2_index == 5'd0) rs2_data = '0;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else if (wr_en_p0) begin
            regs[mmu_index_rd] <= mmu_wb_data;
        end
    end

    // Stage p1: commit trace, retire count and halt FSM
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state        <= RUN;
            halt         <= 1'b0;
            exit_code    <= '0;
            retire_cnt   <= '0;
            commit_valid <= 1'b0;
            commit_pc    <= '0;
            commit_instr <= '0;
        end else begin
            commit_valid <= vld_p0;
            if (vld_p0) begin
                retire_cnt   <= retire_cnt + CNT_W'(1);
                commit_pc    <= mmu_pc;
                commit_instr <= mmu_instr;
            end
            case (state)
                RUN: begin
                    if (vld_p0 && mmu_ebreak_en) begin
                        state     <= HALT;
                        halt      <= 1'b1;
                        exit_code <= a0_p0;
                    end
                end
                HALT: begin
                    state <= HALT;
                    halt  <= 1'b1;
                end
                default: begin
                    state <= RUN;
                    halt  <= 1'b0;
                end
            endcase
        end
    end

endmodule
